// File: rtl/wb_bus_arb_pkg.sv
// Shared types and defaults for the KSM terminal Wishbone bus arbiter.
// Defines the handover state encoding and the bus owner codes.
package ksm_arb_pkg;

  typedef enum logic [1:0] {
    CPU_OWN = 2'd0,
    HAND_D  = 2'd1,
    DMA_OWN = 2'd2,
    HAND_C  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_DMA = 1'b1
  } owner_e;

  localparam int TMO_CYCLES_DEF = 64;
  localparam int DMA_SLICE_DEF  = 16;

endpackage

// File: rtl/wb_bus_arb_if.sv
// Bundle of the CPU, DMA and shared-bus Wishbone signals around the arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface wb_bus_arb_if;

  logic [15:0] cpu_adr_i;
  logic [15:0] cpu_dat_i;
  logic [15:0] cpu_dat_o;
  logic        cpu_cyc_i;
  logic        cpu_stb_i;
  logic        cpu_we_i;
  logic [1:0]  cpu_sel_i;
  logic        cpu_ack_o;
  logic        cpu_gnt_o;

  logic        dma_req_i;
  logic        dma_gnt_o;
  logic [15:0] dma_adr_i;
  logic [15:0] dma_dat_i;
  logic [15:0] dma_dat_o;
  logic        dma_cyc_i;
  logic        dma_stb_i;
  logic        dma_we_i;
  logic [1:0]  dma_sel_i;
  logic        dma_ack_o;

  logic [15:0] wbs_adr_o;
  logic [15:0] wbs_dat_o;
  logic [15:0] wbs_dat_i;
  logic        wbs_cyc_o;
  logic        wbs_stb_o;
  logic        wbs_we_o;
  logic [1:0]  wbs_sel_o;
  logic        wbs_ack_i;

  logic        owner_o;
  logic        tmo_o;
  logic [15:0] tmo_adr_o;

  modport slave (
    input  cpu_adr_i, cpu_dat_i, cpu_cyc_i, cpu_stb_i, cpu_we_i, cpu_sel_i,
    output cpu_dat_o, cpu_ack_o, cpu_gnt_o,
    input  dma_req_i, dma_adr_i, dma_dat_i, dma_cyc_i, dma_stb_i, dma_we_i, dma_sel_i,
    output dma_gnt_o, dma_dat_o, dma_ack_o,
    output wbs_adr_o, wbs_dat_o, wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_sel_o,
    input  wbs_dat_i, wbs_ack_i,
    output owner_o, tmo_o, tmo_adr_o
  );

  modport master (
    output cpu_adr_i, cpu_dat_i, cpu_cyc_i, cpu_stb_i, cpu_we_i, cpu_sel_i,
    input  cpu_dat_o, cpu_ack_o, cpu_gnt_o,
    output dma_req_i, dma_adr_i, dma_dat_i, dma_cyc_i, dma_stb_i, dma_we_i, dma_sel_i,
    input  dma_gnt_o, dma_dat_o, dma_ack_o,
    input  wbs_adr_o, wbs_dat_o, wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_sel_o,
    output wbs_dat_i, wbs_ack_i,
    input  owner_o, tmo_o, tmo_adr_o
  );

endinterface

// File: rtl/wb_bus_arb_tmo.sv
// Bus-timeout watchdog: synthesizes an ack after TMO_CYCLES unanswered strobe
// cycles so an access to an unmapped address cannot hang the bus owner.
module wb_tmo_watchdog #(
  parameter int TMO_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        cyc,
  input  logic        stb,
  input  logic        ack,
  input  logic [15:0] adr,
  output logic        tmo_ack,
  output logic [15:0] tmo_adr
);

  localparam int CW = $clog2(TMO_CYCLES + 1);
  localparam logic [CW-1:0] CNT_TMO = CW'(TMO_CYCLES);

  logic [CW-1:0] cnt_r;
  logic [15:0]   tmo_adr_r;

  // A real ack in the expiry cycle suppresses the synthesized one.
  always_comb begin
    tmo_ack = cyc && stb && !ack && (cnt_r == CNT_TMO);
  end

  // Wait counter and capture of the timed-out address.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r     <= {CW{1'b0}};
      tmo_adr_r <= 16'h0000;
    end else begin
      if (clr || !stb || ack || tmo_ack) begin
        cnt_r <= {CW{1'b0}};
      end else if (cyc) begin
        cnt_r <= cnt_r + CW'(1);
      end else begin
        cnt_r <= cnt_r;
      end
      if (tmo_ack) begin
        tmo_adr_r <= adr;
      end else begin
        tmo_adr_r <= tmo_adr_r;
      end
    end
  end

  assign tmo_adr = tmo_adr_r;

endmodule

// File: rtl/wb_bus_arb.sv
// Wishbone arbiter sharing the KSM system bus between the K1801VM2 CPU and a
// DMA master, with bounded DMA bursts, a CPU anti-starvation yield and a timeout.
module wb_bus_arb
  import ksm_arb_pkg::*;
#(
  parameter int TMO_CYCLES = TMO_CYCLES_DEF,
  parameter int DMA_SLICE  = DMA_SLICE_DEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  wb_bus_arb_if.slave bus
);

  localparam int SW = $clog2(DMA_SLICE + 1);
  localparam logic [SW-1:0] SLICE_MAX  = SW'(DMA_SLICE);
  localparam logic [SW-1:0] SLICE_LAST = SW'(DMA_SLICE - 1);

  arb_state_e    state_r;
  owner_e        owner_r;
  logic          cpu_gnt_r;
  logic          dma_gnt_r;
  logic          yield_r;
  logic          idle_r;
  logic [SW-1:0] slice_cnt_r;

  logic          cpu_ack_s;
  logic          dma_ack_s;
  logic          tmo_ack_s;
  logic [15:0]   tmo_adr_s;
  logic          slice_done_s;
  logic          owner_chg_s;
  logic          yield_clr_s;

  // Shared-bus request mux: the owner's signals pass straight through.
  always_comb begin
    if (owner_r == OWNER_DMA) begin
      bus.wbs_adr_o = bus.dma_adr_i;
      bus.wbs_dat_o = bus.dma_dat_i;
      bus.wbs_cyc_o = bus.dma_cyc_i;
      bus.wbs_stb_o = bus.dma_stb_i;
      bus.wbs_we_o  = bus.dma_we_i;
      bus.wbs_sel_o = bus.dma_sel_i;
    end else begin
      bus.wbs_adr_o = bus.cpu_adr_i;
      bus.wbs_dat_o = bus.cpu_dat_i;
      bus.wbs_cyc_o = bus.cpu_cyc_i;
      bus.wbs_stb_o = bus.cpu_stb_i;
      bus.wbs_we_o  = bus.cpu_we_i;
      bus.wbs_sel_o = bus.cpu_sel_i;
    end
  end

  // Response steering; a synthesized ack returns zero data.
  always_comb begin
    cpu_ack_s     = 1'b0;
    dma_ack_s     = 1'b0;
    bus.cpu_dat_o = 16'h0000;
    bus.dma_dat_o = 16'h0000;
    if (owner_r == OWNER_DMA) begin
      dma_ack_s     = bus.wbs_ack_i | tmo_ack_s;
      bus.dma_dat_o = tmo_ack_s ? 16'h0000 : bus.wbs_dat_i;
    end else begin
      cpu_ack_s     = bus.wbs_ack_i | tmo_ack_s;
      bus.cpu_dat_o = tmo_ack_s ? 16'h0000 : bus.wbs_dat_i;
    end
  end

  // Handover conditions derived from the current state.
  always_comb begin
    slice_done_s = (slice_cnt_r >= SLICE_MAX) ||
                   (dma_ack_s && (slice_cnt_r == SLICE_LAST));
    owner_chg_s  = ((state_r == HAND_D) && !bus.cpu_cyc_i) ||
                   ((state_r == HAND_C) && !bus.dma_cyc_i);
    yield_clr_s  = cpu_ack_s ||
                   ((state_r == CPU_OWN) && !bus.cpu_cyc_i && idle_r);
  end

  // Ownership FSM with registered grants, slice counter and yield flag.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state_r     <= CPU_OWN;
      owner_r     <= OWNER_CPU;
      cpu_gnt_r   <= 1'b1;
      dma_gnt_r   <= 1'b0;
      yield_r     <= 1'b0;
      idle_r      <= 1'b0;
      slice_cnt_r <= {SW{1'b0}};
    end else begin
      idle_r <= (state_r == CPU_OWN) && !bus.cpu_cyc_i;

      if ((state_r == HAND_C) && !bus.dma_cyc_i) begin
        slice_cnt_r <= {SW{1'b0}};
      end else if (dma_ack_s && (slice_cnt_r != SLICE_MAX)) begin
        slice_cnt_r <= slice_cnt_r + SW'(1);
      end else begin
        slice_cnt_r <= slice_cnt_r;
      end

      // Only a forced yield with DMA still requesting blocks the next grant.
      if ((state_r == DMA_OWN) && slice_done_s && bus.dma_req_i) begin
        yield_r <= 1'b1;
      end else if (yield_clr_s) begin
        yield_r <= 1'b0;
      end else begin
        yield_r <= yield_r;
      end

      case (state_r)
        CPU_OWN: begin
          if (bus.dma_req_i && !yield_r) begin
            state_r   <= HAND_D;
            cpu_gnt_r <= 1'b0;
          end
        end
        HAND_D: begin
          if (!bus.cpu_cyc_i) begin
            state_r   <= DMA_OWN;
            owner_r   <= OWNER_DMA;
            dma_gnt_r <= 1'b1;
          end
        end
        DMA_OWN: begin
          if (!bus.dma_req_i || slice_done_s) begin
            state_r   <= HAND_C;
            dma_gnt_r <= 1'b0;
          end
        end
        HAND_C: begin
          if (!bus.dma_cyc_i) begin
            state_r   <= CPU_OWN;
            owner_r   <= OWNER_CPU;
            cpu_gnt_r <= 1'b1;
          end
        end
        default: begin
          state_r   <= CPU_OWN;
          owner_r   <= OWNER_CPU;
          cpu_gnt_r <= 1'b1;
          dma_gnt_r <= 1'b0;
        end
      endcase
    end
  end

  wb_tmo_watchdog #(
    .TMO_CYCLES (TMO_CYCLES)
  ) u_tmo (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_i),
    .clr     (owner_chg_s),
    .cyc     (bus.wbs_cyc_o),
    .stb     (bus.wbs_stb_o),
    .ack     (bus.wbs_ack_i),
    .adr     (bus.wbs_adr_o),
    .tmo_ack (tmo_ack_s),
    .tmo_adr (tmo_adr_s)
  );

  assign bus.cpu_ack_o = cpu_ack_s;
  assign bus.dma_ack_o = dma_ack_s;
  assign bus.cpu_gnt_o = cpu_gnt_r;
  assign bus.dma_gnt_o = dma_gnt_r;
  assign bus.owner_o   = owner_r;
  assign bus.tmo_o     = tmo_ack_s;
  assign bus.tmo_adr_o = tmo_adr_s;

endmodule

// File: tb/tb_wb_bus_arb.sv
// Directed bench for wb_bus_arb: grant handover, in-flight CPU cycles, DMA
// slice yield, bus timeout, ack/timeout race and reset during a DMA burst.
module tb_wb_bus_arb;

  logic clk = 1'b0;
  logic rst_n;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  wb_bus_arb_if bus_if ();

  wb_bus_arb #(
    .TMO_CYCLES (64),
    .DMA_SLICE  (16)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst_n),
    .bus      (bus_if.slave)
  );

  always #5 clk = ~clk;

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic sample;
    @(negedge clk);
  endtask

  task automatic clear_inputs;
    bus_if.cpu_adr_i = 16'h0000; bus_if.cpu_dat_i = 16'h0000;
    bus_if.cpu_cyc_i = 1'b0; bus_if.cpu_stb_i = 1'b0; bus_if.cpu_we_i = 1'b0;
    bus_if.cpu_sel_i = 2'b00;
    bus_if.dma_req_i = 1'b0;
    bus_if.dma_adr_i = 16'h0000; bus_if.dma_dat_i = 16'h0000;
    bus_if.dma_cyc_i = 1'b0; bus_if.dma_stb_i = 1'b0; bus_if.dma_we_i = 1'b0;
    bus_if.dma_sel_i = 2'b00;
    bus_if.wbs_dat_i = 16'h0000; bus_if.wbs_ack_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    clear_inputs();
    next_cycle(); next_cycle();
    sample();
    vec_cnt++; if (bus_if.cpu_gnt_o !== 1'b1) begin err_cnt++; $display("FAIL rst_cpu_gnt: got %b expected 1", bus_if.cpu_gnt_o); end
    vec_cnt++; if (bus_if.dma_gnt_o !== 1'b0) begin err_cnt++; $display("FAIL rst_dma_gnt: got %b expected 0", bus_if.dma_gnt_o); end
    vec_cnt++; if (bus_if.owner_o !== 1'b0) begin err_cnt++; $display("FAIL rst_owner: got %b expected 0", bus_if.owner_o); end
    vec_cnt++; if (bus_if.tmo_o !== 1'b0) begin err_cnt++; $display("FAIL rst_tmo: got %b expected 0", bus_if.tmo_o); end
    vec_cnt++; if (bus_if.tmo_adr_o !== 16'h0000) begin err_cnt++; $display("FAIL rst_tmo_adr: got %o expected 0", bus_if.tmo_adr_o); end
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_dma_grant;
    next_cycle();
    bus_if.dma_req_i = 1'b1;
    bus_if.cpu_adr_i = 16'h1234;
    sample();
    vec_cnt++; if (bus_if.cpu_gnt_o !== 1'b1) begin err_cnt++; $display("FAIL dg_cpu_gnt_c0: got %b expected 1", bus_if.cpu_gnt_o); end
    next_cycle();
    sample();
    vec_cnt++; if (bus_if.cpu_gnt_o !== 1'b0) begin err_cnt++; $display("FAIL dg_cpu_gnt_c1: got %b expected 0", bus_if.cpu_gnt_o); end
    vec_cnt++; if (bus_if.dma_gnt_o !== 1'b0) begin err_cnt++; $display("FAIL dg_dma_gnt_c1: got %b expected 0", bus_if.dma_gnt_o); end
    next_cycle();
    bus_if.dma_cyc_i = 1'b1; bus_if.dma_stb_i = 1'b1; bus_if.dma_we_i = 1'b1;
    bus_if.dma_adr_i = 16'o140000; bus_if.dma_dat_i = 16'o123; bus_if.dma_sel_i = 2'b11;
    sample();
    vec_cnt++; if (bus_if.dma_gnt_o !== 1'b1) begin err_cnt++; $display("FAIL dg_dma_gnt_c2: got %b expected 1", bus_if.dma_gnt_o); end
    vec_cnt++; if (bus_if.owner_o !== 1'b1) begin err_cnt++; $display("FAIL dg_owner_c2: got %b expected 1", bus_if.owner_o); end
    vec_cnt++; if (bus_if.wbs_adr_o !== 16'o140000) begin err_cnt++; $display("FAIL dg_wbs_adr: got %o expected 140000", bus_if.wbs_adr_o); end
    vec_cnt++; if (bus_if.wbs_dat_o !== 16'o123) begin err_cnt++; $display("FAIL dg_wbs_dat: got %o expected 123", bus_if.wbs_dat_o); end
    vec_cnt++; if ({bus_if.wbs_cyc_o, bus_if.wbs_stb_o, bus_if.wbs_we_o} !== 3'b111) begin err_cnt++; $display("FAIL dg_wbs_ctl: got %b expected 111", {bus_if.wbs_cyc_o, bus_if.wbs_stb_o, bus_if.wbs_we_o}); end
    vec_cnt++; if (bus_if.dma_ack_o !== 1'b0) begin err_cnt++; $display("FAIL dg_dma_ack_pre: got %b expected 0", bus_if.dma_ack_o); end
    next_cycle();
    bus_if.wbs_ack_i = 1'b1;
    sample();
    vec_cnt++; if (bus_if.dma_ack_o !== 1'b1) begin err_cnt++; $display("FAIL dg_dma_ack: got %b expected 1", bus_if.dma_ack_o); end
    vec_cnt++; if (bus_if.cpu_ack_o !== 1'b0) begin err_cnt++; $display("FAIL dg_cpu_ack: got %b expected 0", bus_if.cpu_ack_o); end
    next_cycle();
    bus_if.wbs_ack_i = 1'b0;
    bus_if.dma_cyc_i = 1'b0; bus_if.dma_stb_i = 1'b0; bus_if.dma_we_i = 1'b0;
    bus_if.dma_req_i = 1'b0;
    next_cycle();
    sample();
    vec_cnt++; if ({bus_if.dma_gnt_o, bus_if.owner_o} !== 2'b01) begin err_cnt++; $display("FAIL dg_hand_c: got %b expected 01", {bus_if.dma_gnt_o, bus_if.owner_o}); end
    next_cycle();
    sample();
    vec_cnt++; if ({bus_if.cpu_gnt_o, bus_if.owner_o} !== 2'b10) begin err_cnt++; $display("FAIL dg_back_cpu: got %b expected 10", {bus_if.cpu_gnt_o, bus_if.owner_o}); end
  endtask

  task automatic test_cpu_inflight;
    next_cycle();
    bus_if.cpu_cyc_i = 1'b1; bus_if.cpu_stb_i = 1'b1; bus_if.cpu_we_i = 1'b0;
    bus_if.cpu_adr_i = 16'o160000; bus_if.cpu_sel_i = 2'b11;
    bus_if.dma_req_i = 1'b1;
    bus_if.wbs_dat_i = 16'hBEEF;
    sample();
    vec_cnt++; if (bus_if.wbs_adr_o !== 16'o160000) begin err_cnt++; $display("FAIL if_wbs_adr: got %o expected 160000", bus_if.wbs_adr_o); end
    for (int k = 1; k <= 4; k++) begin
      next_cycle();
      sample();
      vec_cnt++; if (bus_if.dma_gnt_o !== 1'b0) begin err_cnt++; $display("FAIL if_dma_gnt_wait%0d: got %b expected 0", k, bus_if.dma_gnt_o); end
    end
    next_cycle();
    bus_if.wbs_ack_i = 1'b1;
    sample();
    vec_cnt++; if (bus_if.cpu_ack_o !== 1'b1) begin err_cnt++; $display("FAIL if_cpu_ack: got %b expected 1", bus_if.cpu_ack_o); end
    vec_cnt++; if (bus_if.cpu_dat_o !== 16'hBEEF) begin err_cnt++; $display("FAIL if_cpu_dat: got %h expected beef", bus_if.cpu_dat_o); end
    vec_cnt++; if (bus_if.dma_ack_o !== 1'b0) begin err_cnt++; $display("FAIL if_dma_ack: got %b expected 0", bus_if.dma_ack_o); end
    next_cycle();
    bus_if.wbs_ack_i = 1'b0;
    bus_if.cpu_cyc_i = 1'b0; bus_if.cpu_stb_i = 1'b0;
    sample();
    vec_cnt++; if (bus_if.dma_gnt_o !== 1'b0) begin err_cnt++; $display("FAIL if_dma_gnt_c6: got %b expected 0", bus_if.dma_gnt_o); end
    next_cycle();
    sample();
    vec_cnt++; if (bus_if.dma_gnt_o !== 1'b1) begin err_cnt++; $display("FAIL if_dma_gnt_c7: got %b expected 1", bus_if.dma_gnt_o); end
    next_cycle();
    bus_if.dma_req_i = 1'b0;
    next_cycle();
    next_cycle();
  endtask

  task automatic test_slice_yield;
    next_cycle();
    bus_if.dma_req_i = 1'b1;
    next_cycle();
    next_cycle();
    bus_if.dma_cyc_i = 1'b1; bus_if.dma_stb_i = 1'b1; bus_if.dma_we_i = 1'b1;
    bus_if.dma_adr_i = 16'o140002; bus_if.wbs_ack_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      sample();
      vec_cnt++; if ({bus_if.dma_ack_o, bus_if.dma_gnt_o} !== 2'b11) begin err_cnt++; $display("FAIL sy_burst%0d: got ack,gnt=%b expected 11", i, {bus_if.dma_ack_o, bus_if.dma_gnt_o}); end
      next_cycle();
    end
    bus_if.dma_cyc_i = 1'b0; bus_if.dma_stb_i = 1'b0; bus_if.dma_we_i = 1'b0;
    bus_if.wbs_ack_i = 1'b0;
    sample();
    vec_cnt++; if (bus_if.dma_gnt_o !== 1'b0) begin err_cnt++; $display("FAIL sy_dma_gnt_drop: got %b expected 0", bus_if.dma_gnt_o); end
    next_cycle();
    bus_if.cpu_cyc_i = 1'b1; bus_if.cpu_stb_i = 1'b1; bus_if.cpu_we_i = 1'b0;
    bus_if.cpu_adr_i = 16'o160002; bus_if.wbs_ack_i = 1'b1; bus_if.wbs_dat_i = 16'h0A5A;
    sample();
    vec_cnt++; if ({bus_if.cpu_gnt_o, bus_if.owner_o} !== 2'b10) begin err_cnt++; $display("FAIL sy_cpu_back: got %b expected 10", {bus_if.cpu_gnt_o, bus_if.owner_o}); end
    vec_cnt++; if (bus_if.cpu_dat_o !== 16'h0A5A) begin err_cnt++; $display("FAIL sy_cpu_dat: got %h expected 0a5a", bus_if.cpu_dat_o); end
    next_cycle();
    bus_if.cpu_cyc_i = 1'b0; bus_if.cpu_stb_i = 1'b0; bus_if.wbs_ack_i = 1'b0;
    sample();
    vec_cnt++; if (bus_if.cpu_gnt_o !== 1'b1) begin err_cnt++; $display("FAIL sy_yield_hold: got %b expected 1", bus_if.cpu_gnt_o); end
    next_cycle();
    sample();
    vec_cnt++; if (bus_if.cpu_gnt_o !== 1'b0) begin err_cnt++; $display("FAIL sy_regrant_hand: got %b expected 0", bus_if.cpu_gnt_o); end
    next_cycle();
    sample();
    vec_cnt++; if (bus_if.dma_gnt_o !== 1'b1) begin err_cnt++; $display("FAIL sy_regrant_dma: got %b expected 1", bus_if.dma_gnt_o); end
    next_cycle();
    bus_if.dma_req_i = 1'b0;
    next_cycle();
    next_cycle();
  endtask

  task automatic test_timeout;
    next_cycle();
    bus_if.cpu_cyc_i = 1'b1; bus_if.cpu_stb_i = 1'b1; bus_if.cpu_we_i = 1'b0;
    bus_if.cpu_adr_i = 16'o177000; bus_if.wbs_dat_i = 16'hFFFF;
    for (int k = 0; k < 64; k++) begin
      sample();
      vec_cnt++; if ({bus_if.cpu_ack_o, bus_if.tmo_o} !== 2'b00) begin err_cnt++; $display("FAIL to_early%0d: got ack,tmo=%b expected 00", k, {bus_if.cpu_ack_o, bus_if.tmo_o}); end
      next_cycle();
    end
    sample();
    vec_cnt++; if (bus_if.cpu_ack_o !== 1'b1) begin err_cnt++; $display("FAIL to_ack: got %b expected 1", bus_if.cpu_ack_o); end
    vec_cnt++; if (bus_if.cpu_dat_o !== 16'h0000) begin err_cnt++; $display("FAIL to_dat: got %h expected 0000", bus_if.cpu_dat_o); end
    vec_cnt++; if (bus_if.tmo_o !== 1'b1) begin err_cnt++; $display("FAIL to_pulse: got %b expected 1", bus_if.tmo_o); end
    next_cycle();
    bus_if.cpu_cyc_i = 1'b0; bus_if.cpu_stb_i = 1'b0;
    sample();
    vec_cnt++; if (bus_if.tmo_o !== 1'b0) begin err_cnt++; $display("FAIL to_pulse_end: got %b expected 0", bus_if.tmo_o); end
    vec_cnt++; if (bus_if.tmo_adr_o !== 16'o177000) begin err_cnt++; $display("FAIL to_adr: got %o expected 177000", bus_if.tmo_adr_o); end
  endtask

  task automatic test_tmo_race;
    next_cycle();
    bus_if.cpu_cyc_i = 1'b1; bus_if.cpu_stb_i = 1'b1; bus_if.cpu_we_i = 1'b0;
    bus_if.cpu_adr_i = 16'o170000; bus_if.wbs_dat_i = 16'h1357;
    repeat (64) next_cycle();
    bus_if.wbs_ack_i = 1'b1;
    sample();
    vec_cnt++; if (bus_if.cpu_ack_o !== 1'b1) begin err_cnt++; $display("FAIL tr_ack: got %b expected 1", bus_if.cpu_ack_o); end
    vec_cnt++; if (bus_if.cpu_dat_o !== 16'h1357) begin err_cnt++; $display("FAIL tr_dat: got %h expected 1357", bus_if.cpu_dat_o); end
    vec_cnt++; if (bus_if.tmo_o !== 1'b0) begin err_cnt++; $display("FAIL tr_no_tmo: got %b expected 0", bus_if.tmo_o); end
    next_cycle();
    bus_if.wbs_ack_i = 1'b0;
    bus_if.cpu_cyc_i = 1'b0; bus_if.cpu_stb_i = 1'b0;
    sample();
    vec_cnt++; if (bus_if.cpu_ack_o !== 1'b0) begin err_cnt++; $display("FAIL tr_single_ack: got %b expected 0", bus_if.cpu_ack_o); end
    vec_cnt++; if (bus_if.tmo_adr_o !== 16'o177000) begin err_cnt++; $display("FAIL tr_adr_kept: got %o expected 177000", bus_if.tmo_adr_o); end
  endtask

  task automatic test_reset_in_dma;
    next_cycle();
    bus_if.dma_req_i = 1'b1;
    next_cycle();
    next_cycle();
    bus_if.dma_cyc_i = 1'b1; bus_if.dma_stb_i = 1'b1; bus_if.dma_adr_i = 16'o140004;
    sample();
    vec_cnt++; if (bus_if.dma_gnt_o !== 1'b1) begin err_cnt++; $display("FAIL rd_in_dma: got %b expected 1", bus_if.dma_gnt_o); end
    next_cycle();
    rst_n = 1'b0;
    clear_inputs();
    next_cycle();
    sample();
    vec_cnt++; if ({bus_if.cpu_gnt_o, bus_if.dma_gnt_o} !== 2'b10) begin err_cnt++; $display("FAIL rd_first_edge: got %b expected 10", {bus_if.cpu_gnt_o, bus_if.dma_gnt_o}); end
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    sample();
    vec_cnt++; if (bus_if.cpu_gnt_o !== 1'b1) begin err_cnt++; $display("FAIL rd_cpu_gnt: got %b expected 1", bus_if.cpu_gnt_o); end
    vec_cnt++; if (bus_if.dma_gnt_o !== 1'b0) begin err_cnt++; $display("FAIL rd_dma_gnt: got %b expected 0", bus_if.dma_gnt_o); end
    vec_cnt++; if (bus_if.owner_o !== 1'b0) begin err_cnt++; $display("FAIL rd_owner: got %b expected 0", bus_if.owner_o); end
    vec_cnt++; if (bus_if.tmo_adr_o !== 16'h0000) begin err_cnt++; $display("FAIL rd_tmo_adr: got %o expected 0", bus_if.tmo_adr_o); end
  endtask

  initial begin
    test_reset();
    test_dma_grant();
    test_cpu_inflight();
    test_slice_yield();
    test_timeout();
    test_tmo_race();
    test_reset_in_dma();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete within 100000 ns");
    $fatal(1, "bench time limit expired");
  end

endmodule
